// File: rtl/unsigned8div_pkg.sv
// Shared types and constants for the unsigned 16/8 restoring divider.
package unsigned8div_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int QUOT_W     = 8;
   localparam int STEPS      = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [2:0] step_t;

   // A quotient wider than 8 bits (or no quotient at all) is reported as overflow.
   function automatic logic lane_ovf(input logic [DIVIDEND_W-1:0] dividend,
                                     input logic [DIVISOR_W-1:0]  div);
      return (div == '0) || (dividend[DIVIDEND_W-1:QUOT_W] >= div);
   endfunction

endpackage

// File: rtl/unsigned8div_div_step_unit.sv
// One restoring-division step for one lane: register holds {remainder, dividend/quotient bits}.
module div_step_unit
   import unsigned8div_pkg::*;
(
   input  logic [DIVIDEND_W-1:0] iRq,
   input  logic [DIVISOR_W-1:0]  iDiv,
   output logic [DIVIDEND_W-1:0] oRq
);

   logic                 ge;
   logic [DIVISOR_W-1:0] diff;

   // The 9-bit trial value {rem, next bit} never exceeds 2*div-1, so an
   // 8-bit modular difference is exact whenever the subtraction succeeds.
   always_comb begin
      ge   = (iRq[DIVIDEND_W-1:QUOT_W-1] >= {1'b0, iDiv});
      diff = iRq[DIVIDEND_W-2:QUOT_W-1] - iDiv;
      if (ge) begin
         oRq = {diff, iRq[QUOT_W-2:0], 1'b1};
      end else begin
         oRq = {iRq[DIVIDEND_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/unsigned8div.sv
// Sequential unsigned 16/8 divider, one shared divisor broadcast to B_NUM dividend lanes.
// Optional macro UNSIGNED8DIV_FAST_EXC_EN: all-overflow operations skip RUN and finish at accept.
module unsigned8div
   import unsigned8div_pkg::*;
#(
   parameter int B_NUM = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 iDivEn,
   input  logic [DIVISOR_W-1:0]                 iDivisor,
   input  logic                                 iValid,
   output logic                                 oReady,
   input  logic [B_NUM-1:0][DIVIDEND_W-1:0]     iDividend,
   output logic                                 oValid,
   input  logic                                 iReady,
   output logic [B_NUM-1:0][QUOT_W-1:0]         oQuot,
   output logic [B_NUM-1:0][QUOT_W-1:0]         oRem,
   output logic [B_NUM-1:0]                     oOvf,
   output logic                                 oDivZero,
   output state_t                               oState
);

   // Handshake: a request is taken on a rising edge with iValid && oReady
   // (oReady == IDLE); a result is handed over on a rising edge with
   // oValid && iReady (oValid == DONE), and stays put until then.

   state_t                          state_q, state_d;
   step_t                           step_q;
   logic [DIVISOR_W-1:0]            div_q;
   logic [DIVISOR_W-1:0]            div_eff;
   logic [B_NUM-1:0][DIVIDEND_W-1:0] rq_q;
   logic [DIVIDEND_W-1:0]           rq_nxt [B_NUM];
   logic [B_NUM-1:0][QUOT_W-1:0]    lo_q;
   logic [B_NUM-1:0]                ovf_q;
   logic [B_NUM-1:0]                ovf_acc;
   logic                            dz_q;
   logic                            accept;
   logic                            finish_run;
`ifdef UNSIGNED8DIV_FAST_EXC_EN
   logic                            fast_done;
`endif

   assign div_eff = iDivEn ? iDivisor : div_q;
   assign accept  = (state_q == IDLE) && iValid;
   assign oReady  = (state_q == IDLE);
   assign oValid  = (state_q == DONE);
   assign oState  = state_q;

   always_comb begin
      ovf_acc = '0;
      for (int l = 0; l < B_NUM; l++) begin
         ovf_acc[l] = lane_ovf(iDividend[l], div_eff);
      end
   end

   for (genvar g = 0; g < B_NUM; g++) begin : g_lane
      div_step_unit u_step (
         .iRq  (rq_q[g]),
         .iDiv (div_q),
         .oRq  (rq_nxt[g])
      );
   end

   always_comb begin
      state_d    = state_q;
      finish_run = 1'b0;
`ifdef UNSIGNED8DIV_FAST_EXC_EN
      fast_done  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (iValid) begin
`ifdef UNSIGNED8DIV_FAST_EXC_EN
               if (&ovf_acc) begin
                  state_d   = DONE;
                  fast_done = 1'b1;
               end else begin
                  state_d = RUN;
               end
`else
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            if (step_q == step_t'(STEPS - 1)) begin
               state_d    = DONE;
               finish_run = 1'b1;
            end
         end
         DONE: begin
            if (iReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         step_q   <= '0;
         div_q    <= '0;
         rq_q     <= '0;
         lo_q     <= '0;
         ovf_q    <= '0;
         dz_q     <= 1'b0;
         oQuot    <= '0;
         oRem     <= '0;
         oOvf     <= '0;
         oDivZero <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && iDivEn) div_q <= iDivisor;

         if (accept) begin
            rq_q   <= iDividend;
            ovf_q  <= ovf_acc;
            dz_q   <= (div_eff == '0);
            step_q <= '0;
            for (int l = 0; l < B_NUM; l++) lo_q[l] <= iDividend[l][QUOT_W-1:0];
         end else if (state_q == RUN) begin
            for (int l = 0; l < B_NUM; l++) rq_q[l] <= rq_nxt[l];
            step_q <= step_q + step_t'(1);
         end

         if (finish_run) begin
            oDivZero <= dz_q;
            oOvf     <= ovf_q;
            for (int l = 0; l < B_NUM; l++) begin
               if (ovf_q[l]) begin
                  oQuot[l] <= '1;
                  oRem[l]  <= lo_q[l];
               end else begin
                  oQuot[l] <= rq_nxt[l][QUOT_W-1:0];
                  oRem[l]  <= rq_nxt[l][DIVIDEND_W-1:QUOT_W];
               end
            end
         end
`ifdef UNSIGNED8DIV_FAST_EXC_EN
         if (fast_done) begin
            oDivZero <= (div_eff == '0);
            oOvf     <= '1;
            for (int l = 0; l < B_NUM; l++) begin
               oQuot[l] <= '1;
               oRem[l]  <= iDividend[l][QUOT_W-1:0];
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_unsigned8div.sv
// Self-checking bench for unsigned8div with two lanes; results are scoreboarded against a / and % model.
module tb_unsigned8div;
   import unsigned8div_pkg::*;

   localparam int LANES = 2;
   localparam int RW    = 1 + LANES + 2 * LANES * 8;

   logic                           clk = 1'b0;
   logic                           rst = 1'b0;
   logic                           iDivEn = 1'b0;
   logic [7:0]                     iDivisor = '0;
   logic                           iValid = 1'b0;
   logic                           oReady;
   logic [LANES-1:0][15:0]         iDividend = '0;
   logic                           oValid;
   logic                           iReady = 1'b1;
   logic [LANES-1:0][7:0]          oQuot;
   logic [LANES-1:0][7:0]          oRem;
   logic [LANES-1:0]               oOvf;
   logic                           oDivZero;
   state_t                         oState;

   logic [RW-1:0] exp_q[$];
   logic [7:0]    div_model = '0;
   int            n_vec  = 0;
   int            n_fail = 0;

   unsigned8div #(.B_NUM(LANES)) dut (
      .clk(clk), .rst(rst), .iDivEn(iDivEn), .iDivisor(iDivisor),
      .iValid(iValid), .oReady(oReady), .iDividend(iDividend),
      .oValid(oValid), .iReady(iReady), .oQuot(oQuot), .oRem(oRem),
      .oOvf(oOvf), .oDivZero(oDivZero), .oState(oState)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic logic [16:0] lane_model(input logic [15:0] d, input logic [7:0] v);
      logic [15:0] q, r;
      if (v == 8'd0 || d[15:8] >= v) return {1'b1, 8'hFF, d[7:0]};
      q = d / {8'd0, v};
      r = d % {8'd0, v};
      return {1'b0, q[7:0], r[7:0]};
   endfunction

   function automatic logic [RW-1:0] expect_res(input logic [7:0] v, input logic [15:0] d0,
                                                input logic [15:0] d1);
      logic [16:0] l0, l1;
      l0 = lane_model(d0, v);
      l1 = lane_model(d1, v);
      return {(v == 8'd0), l1[16], l0[16], l1[15:8], l0[15:8], l1[7:0], l0[7:0]};
   endfunction

   // Rising edges from the accept edge until oValid is visible.
   function automatic int exp_latency(input logic [7:0] v, input logic [15:0] d0,
                                      input logic [15:0] d1);
      logic [16:0] l0, l1;
      l0 = lane_model(d0, v);
      l1 = lane_model(d1, v);
`ifdef UNSIGNED8DIV_FAST_EXC_EN
      if (l0[16] && l1[16]) return 0;
`else
      if (l0[16] && l1[16]) return 8;
`endif
      return 8;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [RW-1:0] act, exp;
      if (rst && oValid && iReady) begin
         act = {oDivZero, oOvf, oQuot, oRem};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL result_unexpected: got %h, no result expected", act);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               n_fail++;
               $display("FAIL result: got %h, want %h (dz,ovf,quot,rem)", act, exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   // Called at posedge+1 with the DUT in IDLE; returns with oValid seen (or timed out).
   task automatic issue(input logic [7:0] v, input bit en, input logic [15:0] d0,
                        input logic [15:0] d1, output int lat, output int elat);
      logic [7:0] eff;
      eff = en ? v : div_model;
      if (en) div_model = v;
      exp_q.push_back(expect_res(eff, d0, d1));
      elat = exp_latency(eff, d0, d1);
      iDivEn = en; iDivisor = v; iDividend = {d1, d0}; iValid = 1'b1;
      @(posedge clk); #1;
      iValid = 1'b0; iDivEn = 1'b0;
      lat = 0;
      while (!oValid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (oReady !== 1'b1 || oValid !== 1'b0) begin
         n_fail++; $display("FAIL reset_hs: ready=%b valid=%b, want 1 0", oReady, oValid);
      end
      n_vec++;
      if ({oQuot, oRem} !== '0 || oOvf !== '0 || oDivZero !== 1'b0) begin
         n_fail++; $display("FAIL reset_out: quot=%h rem=%h ovf=%b dz=%b, want zeros", oQuot, oRem, oOvf, oDivZero);
      end
      n_vec++;
      if (oState !== IDLE) begin
         n_fail++; $display("FAIL reset_state: got %0d, want %0d", oState, IDLE);
      end
      rst = 1'b1;
      div_model = 8'd0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int lat, elat;
      iReady = 1'b1;
      issue(8'd9, 1'b1, 16'd1000, 16'd80, lat, elat);
      n_vec++;
      if (lat !== elat) begin
         n_fail++; $display("FAIL basic_latency: got %0d, want %0d", lat, elat);
      end
      handshake();
      issue(8'd255, 1'b1, 16'd65025, 16'hFF00, lat, elat);
      n_vec++;
      if (lat !== elat) begin
         n_fail++; $display("FAIL max_latency: got %0d, want %0d", lat, elat);
      end
      handshake();
   endtask

   task automatic test_divzero;
      int lat, elat;
      issue(8'd0, 1'b1, 16'h1234, 16'h1234, lat, elat);
      n_vec++;
      if (lat !== elat) begin
         n_fail++; $display("FAIL divzero_latency: got %0d, want %0d", lat, elat);
      end
      n_vec++;
      if (oDivZero !== 1'b1 || oOvf !== 2'b11 || oQuot !== {8'hFF, 8'hFF} || oRem !== {8'h34, 8'h34}) begin
         n_fail++; $display("FAIL divzero_out: dz=%b ovf=%b quot=%h rem=%h, want 1 11 ffff 3434", oDivZero, oOvf, oQuot, oRem);
      end
      handshake();
   endtask

   task automatic test_two_lane;
      int lat, elat;
      issue(8'h12, 1'b1, 16'h1234, 16'h0100, lat, elat);
      n_vec++;
      if (lat !== elat) begin
         n_fail++; $display("FAIL lanes_latency: got %0d, want %0d", lat, elat);
      end
      n_vec++;
      if (oOvf !== 2'b01 || oQuot[1] !== 8'd14 || oRem[1] !== 8'd4) begin
         n_fail++; $display("FAIL lanes_out: ovf=%b q1=%0d r1=%0d, want 01 14 4", oOvf, oQuot[1], oRem[1]);
      end
      handshake();
   endtask

   task automatic test_hold_and_divlock;
      int lat, elat;
      logic [RW-1:0] held;
      iReady = 1'b0;
      fork
         issue(8'd50, 1'b1, 16'd3000, 16'd777, lat, elat);
         begin
            repeat (3) @(posedge clk);
            #2 iDivEn = 1'b1; iDivisor = 8'd3;
            repeat (2) @(posedge clk);
            #2 iDivEn = 1'b0;
         end
      join
      n_vec++;
      if (lat !== elat) begin
         n_fail++; $display("FAIL hold_latency: got %0d, want %0d", lat, elat);
      end
      held = (exp_q.size() > 0) ? exp_q[0] : '0;
      n_vec++;
      if (exp_q.size() != 1) begin
         n_fail++; $display("FAIL hold_queue: got %0d pending, want 1", exp_q.size());
      end
      iValid = 1'b1; iDivEn = 1'b1; iDivisor = 8'd77; iDividend = {16'd9, 16'd9};
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_vec++;
         if (oValid !== 1'b1 || oReady !== 1'b0 || {oDivZero, oOvf, oQuot, oRem} !== held) begin
            n_fail++;
            $display("FAIL hold_stable: cyc %0d valid=%b ready=%b out=%h, want 1 0 %h", c, oValid, oReady,
                     {oDivZero, oOvf, oQuot, oRem}, held);
         end
      end
      iValid = 1'b0; iDivEn = 1'b0; iReady = 1'b1;
      handshake();
      n_vec++;
      if (oValid !== 1'b0 || oReady !== 1'b1 || {oDivZero, oOvf, oQuot, oRem} !== held) begin
         n_fail++; $display("FAIL hold_release: valid=%b ready=%b out=%h, want 0 1 %h", oValid, oReady,
                            {oDivZero, oOvf, oQuot, oRem}, held);
      end
      // Divisor 77 was offered in DONE and must not have been taken.
      issue(8'd0, 1'b0, 16'd1000, 16'd4321, lat, elat);
      n_vec++;
      if (lat !== elat) begin
         n_fail++; $display("FAIL reuse_latency: got %0d, want %0d", lat, elat);
      end
      handshake();
   endtask

   task automatic test_reset_abort;
      int lat, elat, seen;
      iReady = 1'b1;
      iDivEn = 1'b1; iDivisor = 8'd11; iDividend = {16'd600, 16'd500}; iValid = 1'b1;
      @(posedge clk); #1;
      iValid = 1'b0; iDivEn = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      div_model = 8'd0;
      n_vec++;
      if (oValid !== 1'b0 || oReady !== 1'b1 || oState !== IDLE) begin
         n_fail++; $display("FAIL abort_state: valid=%b ready=%b state=%0d, want 0 1 0", oValid, oReady, oState);
      end
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (oValid) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_fail++; $display("FAIL abort_stale: got %0d valid cycles, want 0", seen);
      end
      issue(8'd7, 1'b1, 16'd100, 16'd200, lat, elat);
      n_vec++;
      if (lat !== elat || oQuot[0] !== 8'd14 || oRem[0] !== 8'd2) begin
         n_fail++; $display("FAIL abort_next: lat=%0d q=%0d r=%0d, want %0d 14 2", lat, oQuot[0], oRem[0], elat);
      end
      handshake();
   endtask

   task automatic test_random;
      int lat, elat, dly;
      logic [7:0] v, eff;
      logic [15:0] d [2];
      bit en;
      for (int i = 0; i < 16; i++) begin
         v   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) v = 8'd0;
         en  = ($urandom_range(0, 3) != 0);
         eff = en ? v : div_model;
         for (int l = 0; l < 2; l++) begin
            d[l] = 16'($urandom_range(0, 65535));
            if (eff != 8'd0 && $urandom_range(0, 3) != 0)
               d[l][15:8] = 8'($urandom_range(0, int'(eff) - 1));
         end
         iReady = 1'b0;
         issue(v, en, d[0], d[1], lat, elat);
         n_vec++;
         if (lat !== elat) begin
            n_fail++; $display("FAIL rand_latency: op %0d got %0d, want %0d", i, lat, elat);
         end
         dly = $urandom_range(0, 3);
         repeat (dly) @(posedge clk);
         #1 iReady = 1'b1;
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_divzero();
      test_two_lane();
      test_hold_and_divlock();
      test_reset_abort();
      test_random();
      repeat (2) @(posedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL drain: %0d results never produced, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
